rtlola_event_sched: RTL and testbench

RTLOLA_EVENT_SCHED -- requirements
Module: rtlola_event_sched

---
 rtl/rtlola_event_sched.sv | 179 +++++++++++++++++
 tb/tb_rtlola_event_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtlola_event_sched.sv
// Event scheduler in front of an RTLola monitor: buffers stamped input events and issues one evaluation per 3 cycles.
// Periodic deadline evaluations exist only when SCHED_DEADLINE_EN is defined.
module rtlola_event_sched #(
   parameter int DATA_W = 64,
   parameter int TS_W   = 64,
   parameter int DEPTH  = 8,
   parameter int PERIOD = 500
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DATA_W-1:0]  in_data_0,
   input  logic                      in_new_0,
   input  logic signed [DATA_W-1:0]  in_data_1,
   input  logic                      in_new_1,
   input  logic                      mon_ready,
   output logic                      mon_valid,
   output logic [DATA_W-1:0]         mon_input_0,
   output logic                      mon_new_input_0,
   output logic [DATA_W-1:0]         mon_input_1,
   output logic                      mon_new_input_1,
   output logic                      mon_deadline,
   output logic [TS_W-1:0]           mon_tag,
   output logic [$clog2(DEPTH):0]    fill,
   output logic                      overflow,
   output logic                      missed_dl
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef struct packed {
      logic [TS_W-1:0]   ts;
      logic              n1;
      logic [DATA_W-1:0] d1;
      logic              n0;
      logic [DATA_W-1:0] d0;
   } ev_t;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t          state_q, state_d;
   logic [TS_W-1:0] time_q;
   logic [PW-1:0]   wr_q, rd_q, fill_w;
   ev_t             mem_q [DEPTH];
   ev_t             head, dl_ev, out_q;
   logic            out_dl_q, ovf_q;
   logic            empty, full, any_new, push, drop;
   logic            dl_pend, missed;
   logic [TS_W-1:0] dl_ts, ts_diff;
   logic            pick_ev, take, take_ev;

   assign fill_w   = wr_q - rd_q;
   assign empty    = (fill_w == '0);
   assign full     = (fill_w == PW'(DEPTH));
   assign any_new  = in_new_0 | in_new_1;
   assign in_ready = ~full & en;
   assign push     = in_valid & in_ready & any_new;
   // in_ready is registered-fill based, so a same-cycle pop never makes room for a push at full
   assign drop     = en & in_valid & ~in_ready & any_new;
   assign head     = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         time_q <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         ovf_q  <= 1'b0;
      end else if (en) begin
         time_q <= time_q + 1'b1;
         wr_q   <= wr_q + PW'(push);
         rd_q   <= rd_q + PW'(take_ev);
         ovf_q  <= ovf_q | drop;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q[AW-1:0]] <= '{ts: time_q, n1: in_new_1, d1: in_data_1,
                                  n0: in_new_0, d0: in_data_0};
      end
   end

`ifdef SCHED_DEADLINE_EN
   localparam int CW = $clog2(PERIOD);
   logic [CW-1:0]   dl_cnt_q;
   logic            dl_pend_q, missed_q, wrap, take_dl;
   logic [TS_W-1:0] dl_ts_q;

   assign wrap    = (dl_cnt_q == CW'(PERIOD - 1));
   assign take_dl = take & ~pick_ev;

   always_ff @(posedge clk) begin
      if (rst) begin
         dl_cnt_q  <= '0;
         dl_pend_q <= 1'b0;
         dl_ts_q   <= '0;
         missed_q  <= 1'b0;
      end else if (en) begin
         dl_cnt_q <= wrap ? '0 : dl_cnt_q + 1'b1;
         if (wrap) begin
            // an unserved deadline is overwritten by the newer one
            dl_pend_q <= 1'b1;
            dl_ts_q   <= time_q;
            missed_q  <= missed_q | (dl_pend_q & ~take_dl);
         end else if (take_dl) begin
            dl_pend_q <= 1'b0;
         end
      end
   end

   assign dl_pend = dl_pend_q;
   assign dl_ts   = dl_ts_q;
   assign missed  = missed_q;
`else
   assign dl_pend = 1'b0;
   assign dl_ts   = '0;
   assign missed  = 1'b0;
`endif

   // ties and older events win: signed wrap-safe difference <= 0
   assign ts_diff = head.ts - dl_ts;
   assign pick_ev = ~empty & (~dl_pend | ts_diff[TS_W-1] | (ts_diff == '0));

   always_comb begin
      dl_ev    = '0;
      dl_ev.ts = dl_ts;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else if (en) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mon_ready && (!empty || dl_pend)) state_d = ISSUE;
         ISSUE:   state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      take      = (state_q == IDLE) & en & mon_ready & (~empty | dl_pend);
      take_ev   = take & pick_ev;
      mon_valid = (state_q == ISSUE) & en & ~rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q    <= '0;
         out_dl_q <= 1'b0;
      end else if (en) begin
         if (take) begin
            out_q    <= pick_ev ? head : dl_ev;
            out_dl_q <= ~pick_ev;
         end else if (state_q == ISSUE) begin
            out_q    <= '0;
            out_dl_q <= 1'b0;
         end
      end
   end

   assign mon_input_0     = out_q.d0;
   assign mon_new_input_0 = out_q.n0;
   assign mon_input_1     = out_q.d1;
   assign mon_new_input_1 = out_q.n1;
   assign mon_deadline    = out_dl_q;
   assign mon_tag         = out_q.ts;
   assign fill            = fill_w;
   assign overflow        = ovf_q;
   assign missed_dl       = missed;
endmodule

// File: tb/tb_rtlola_event_sched.sv
// Bench for rtlola_event_sched: queue-based reference model checked every cycle, plus directed scenarios.
// Deadline scenarios run only when SCHED_DEADLINE_EN is defined.
module tb_rtlola_event_sched;
   localparam int DATA_W = 64;
   localparam int TS_W   = 64;
   localparam int DEPTH  = 8;
   localparam int PERIOD = 500;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, en = 1'b0, in_valid = 1'b0, in_ready;
   logic signed [DATA_W-1:0] in_data_0 = '0, in_data_1 = '0;
   logic in_new_0 = 1'b0, in_new_1 = 1'b0, mon_ready = 1'b0;
   logic mon_valid, mon_new_input_0, mon_new_input_1, mon_deadline, overflow, missed_dl;
   logic [DATA_W-1:0] mon_input_0, mon_input_1;
   logic [TS_W-1:0] mon_tag;
   logic [$clog2(DEPTH):0] fill;

   rtlola_event_sched #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .in_data_0(in_data_0), .in_new_0(in_new_0), .in_data_1(in_data_1), .in_new_1(in_new_1),
      .mon_ready(mon_ready), .mon_valid(mon_valid), .mon_input_0(mon_input_0),
      .mon_new_input_0(mon_new_input_0), .mon_input_1(mon_input_1),
      .mon_new_input_1(mon_new_input_1), .mon_deadline(mon_deadline), .mon_tag(mon_tag),
      .fill(fill), .overflow(overflow), .missed_dl(missed_dl));

   typedef struct {
      logic [63:0] d0, d1, ts;
      bit          n0, n1;
   } ev_s;
   typedef struct {
      logic [63:0] tag, d0;
      bit          dl;
      int          cyc;
   } log_s;

   int n_tests = 0, n_fail = 0, cyc = 0;

   // reference model: pending events in a queue, a pending deadline, and the issue/cool-down phase
   ev_s         q[$];
   log_s        lg[$];
   logic [63:0] m_t, m_dlts;
   int          m_dlc, m_phase;
   bit          m_dlp, m_ovf, m_miss, m_known = 0, m_outdl;
   ev_s         m_out;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input bit e, input bit r, input bit iv, input logic [63:0] a0, input bit b0,
                       input logic [63:0] a1, input bit b1, input bit mr);
      bit   on, room, use_ev;
      ev_s  nev;
      log_s le;
      @(negedge clk);
      en = e; rst = r; in_valid = iv; mon_ready = mr;
      in_data_0 = a0; in_new_0 = b0; in_data_1 = a1; in_new_1 = b1;
      #1;
      if (m_known) begin
         on = (m_phase == 1);
         check("in_ready", in_ready, (q.size() < DEPTH) && e);
         check("fill", 64'(fill), 64'(q.size()));
         check("mon_valid", mon_valid, on && e && !r);
         check("mon_input_0", mon_input_0, on ? m_out.d0 : 64'd0);
         check("mon_input_1", mon_input_1, on ? m_out.d1 : 64'd0);
         check("mon_new_0", mon_new_input_0, on && m_out.n0);
         check("mon_new_1", mon_new_input_1, on && m_out.n1);
         check("mon_deadline", mon_deadline, on && m_outdl);
         check("mon_tag", mon_tag, on ? m_out.ts : 64'd0);
         check("overflow", overflow, m_ovf);
         check("missed_dl", missed_dl, m_miss);
      end
      if (mon_valid === 1'b1) begin
         le.tag = mon_tag; le.d0 = mon_input_0; le.dl = mon_deadline; le.cyc = cyc;
         lg.push_back(le);
      end
      if (r) begin
         q.delete();
         m_t = 0; m_dlc = 0; m_dlp = 0; m_dlts = 0;
         m_ovf = 0; m_miss = 0; m_phase = 0; m_known = 1;
      end else if (e && m_known) begin
         room = (q.size() < DEPTH);
         if (m_phase == 0) begin
            if (mr && (q.size() > 0 || m_dlp)) begin
               use_ev = (q.size() > 0) && (!m_dlp || longint'(q[0].ts - m_dlts) <= 0);
               if (use_ev) begin
                  m_out = q.pop_front();
                  m_outdl = 0;
               end else begin
                  m_out = '{d0: 0, d1: 0, ts: m_dlts, n0: 0, n1: 0};
                  m_outdl = 1;
                  m_dlp = 0;
               end
               m_phase = 1;
            end
         end else if (m_phase == 1) m_phase = 2;
         else m_phase = 0;
         if (iv && (b0 || b1)) begin
            if (room) begin
               nev = '{d0: a0, d1: a1, ts: m_t, n0: b0, n1: b1};
               q.push_back(nev);
            end else m_ovf = 1;
         end
`ifdef SCHED_DEADLINE_EN
         if (m_dlc == PERIOD - 1) begin
            if (m_dlp) m_miss = 1;
            m_dlp = 1; m_dlts = m_t; m_dlc = 0;
         end else m_dlc++;
`endif
         m_t++;
      end
      cyc++;
   endtask

   task automatic idle(input bit mr);
      step(1, 0, 0, 0, 0, 0, 0, mr);
   endtask

   task automatic do_reset();
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [63:0] dtags[$];
      bit nb0, nb1;

      // reset state with en=1 and idle host
      do_reset();
      idle(1);
      check("rst_fill", 64'(fill), 64'd0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_mon_valid", mon_valid, 1'b0);
      check("rst_mon_tag", mon_tag, 64'd0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_missed", missed_dl, 1'b0);

      // single event stamped 1000, valid exactly 2 cycles after accept
      do_reset();
      for (int k = 0; k < 1000; k++) idle(1);
      step(1, 0, 1, 64'd1, 1, 64'd1, 1, 1);
      idle(1);
`ifndef SCHED_DEADLINE_EN
      check("lat_early", mon_valid, 1'b0);
`endif
      idle(1);
`ifndef SCHED_DEADLINE_EN
      check("lat_valid", mon_valid, 1'b1);
      check("lat_in0", mon_input_0, 64'd1);
      check("lat_in1", mon_input_1, 64'd1);
      check("lat_tag", mon_tag, 64'd1000);
      check("lat_dl", mon_deadline, 1'b0);
`endif
      for (int k = 0; k < 3; k++) idle(1);

`ifdef SCHED_DEADLINE_EN
      // free-running deadlines with no events
      do_reset();
      lg.delete();
      for (int k = 0; k < 1510; k++) idle(1);
      foreach (lg[i]) if (lg[i].dl) dtags.push_back(lg[i].tag);
      check("dl_count", 64'(dtags.size()), 64'd3);
      if (dtags.size() >= 3) begin
         check("dl_tag0", dtags[0], 64'd499);
         check("dl_tag1", dtags[1], 64'd999);
         check("dl_tag2", dtags[2], 64'd1499);
      end

      // equal stamps: event first, deadline three cycles later
      do_reset();
      lg.delete();
      for (int k = 0; k < 999; k++) idle(0);
      step(1, 0, 1, 64'd5, 1, 64'd0, 0, 0);
      for (int k = 0; k < 8; k++) idle(1);
      check("tie_count", 64'(lg.size()), 64'd2);
      if (lg.size() >= 2) begin
         check("tie_first_dl", lg[0].dl, 1'b0);
         check("tie_first_tag", lg[0].tag, 64'd999);
         check("tie_second_dl", lg[1].dl, 1'b1);
         check("tie_second_tag", lg[1].tag, 64'd999);
         check("tie_spacing", 64'(lg[1].cyc - lg[0].cyc), 64'd3);
      end
`endif

      // fill to DEPTH, drop the ninth, then drain in order
      do_reset();
      lg.delete();
      for (int i = 0; i < 9; i++) step(1, 0, 1, 64'(i + 1), 1, 64'(i), i[0], 0);
      idle(0);
      check("full_fill", 64'(fill), 64'd8);
      check("full_overflow", overflow, 1'b1);
      check("full_in_ready", in_ready, 1'b0);
      for (int k = 0; k < 30; k++) idle(1);
      check("drain_count", 64'(lg.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < lg.size()) begin
            check("drain_order", lg[i].d0, 64'(i + 1));
            if (i > 0) check("drain_spacing", 64'(lg[i].cyc - lg[i-1].cyc), 64'd3);
         end
      end

      // en=0 holds ISSUE; exactly one pulse once en returns
      do_reset();
      lg.delete();
      step(1, 0, 1, 64'd42, 1, 64'd0, 0, 1);
      idle(1);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 0, 0, 0, 0, 1);
         check("hold_valid", mon_valid, 1'b0);
      end
      idle(1);
      check("hold_pulse", mon_valid, 1'b1);
      for (int k = 0; k < 4; k++) idle(1);
      check("hold_count", 64'(lg.size()), 64'd1);
      if (lg.size() >= 1) check("hold_data", lg[0].d0, 64'd42);

      // reset while in ISSUE suppresses the pulse
      do_reset();
      lg.delete();
      step(1, 0, 1, 64'd7, 1, 64'd0, 0, 1);
      idle(1);
      step(1, 1, 0, 0, 0, 0, 0, 1);
      check("rstiss_valid", mon_valid, 1'b0);
      for (int k = 0; k < 4; k++) idle(1);
      check("rstiss_count", 64'(lg.size()), 64'd0);
      check("rstiss_fill", 64'(fill), 64'd0);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         nb0 = $urandom_range(0, 1);
         nb1 = $urandom_range(0, 1);
         step(($urandom % 8) != 0, ($urandom % 1500) == 0, $urandom_range(0, 1),
              {$urandom, $urandom}, nb0, {$urandom, $urandom}, nb1,
              ((i / 150) % 3 != 0) && ($urandom % 4 != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
